// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display path.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam int MAX_MAG  = 9999;
  localparam int BCD_ITER = 14;

  // Segment codes, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low seven-segment code, with a forced-blank input.
module seg7_encode
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_result_display.sv
// Signed 32-bit result to four seven-segment digits plus sign/error LEDs,
// using a sequential shift-add-3 BCD conversion behind a load/busy/done handshake.
module calc_result_display
  import calc_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        neg_led,
  output logic        err_led
);

  state_t             state;
  logic [3:0]         cnt;
  logic [29:0]        shreg;
  logic               sign_r;
  logic               ovf_r;
  logic               nz_r;

  logic signed [31:0] res_s;
  logic [31:0]        mag;
  logic               ovf;
  logic [15:0]        bcd;
  logic               blank3, blank2, blank1;
  logic [6:0]         seg0, seg1, seg2, seg3;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] o;
    logic [3:0]  nib;
    o = b;
    for (int i = 0; i < 4; i++) begin
      nib = b[i*4 +: 4];
      o[i*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    return o;
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] c);
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  // Magnitude of the most negative value wraps to itself; it is caught as overflow.
  assign res_s = result;
  assign mag   = res_s[31] ? 32'(-res_s) : 32'(res_s);
  assign ovf   = (mag > 32'(MAX_MAG)) || (result == 32'h8000_0000);

  assign bcd    = shreg[29:14];
  assign blank3 = (bcd[15:12] == 4'd0);
  assign blank2 = blank3 && (bcd[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd[7:4] == 4'd0);

  seg7_encode u_seg0 (.digit(bcd[3:0]),   .blank(1'b0),   .seg(seg0));
  seg7_encode u_seg1 (.digit(bcd[7:4]),   .blank(blank1), .seg(seg1));
  seg7_encode u_seg2 (.digit(bcd[11:8]),  .blank(blank2), .seg(seg2));
  seg7_encode u_seg3 (.digit(bcd[15:12]), .blank(blank3), .seg(seg3));

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      done    <= 1'b0;
      hex0    <= pol(SEG_BLANK);
      hex1    <= pol(SEG_BLANK);
      hex2    <= pol(SEG_BLANK);
      hex3    <= pol(SEG_BLANK);
      neg_led <= 1'b0;
      err_led <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sign_r <= result[31];
            ovf_r  <= ovf;
            nz_r   <= |mag;
            shreg  <= {16'd0, mag[13:0]};
            cnt    <= 4'd0;
            state  <= CONV;
          end
        end
        // ---- conversion: one binary bit shifted into the BCD field per clock
        CONV: begin
          shreg <= {bcd_adjust(shreg[29:14]), shreg[13:0]} << 1;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(BCD_ITER - 1)) state <= LATCH;
        end
        // ---- latch: all display outputs change together here
        LATCH: begin
          if (ovf_r) begin
            hex3    <= pol(SEG_E);
            hex2    <= pol(SEG_R);
            hex1    <= pol(SEG_R);
            hex0    <= pol(SEG_BLANK);
            err_led <= 1'b1;
            neg_led <= 1'b0;
          end else begin
            hex3    <= pol(seg3);
            hex2    <= pol(seg2);
            hex1    <= pol(seg1);
            hex0    <= pol(seg0);
            err_led <= 1'b0;
            neg_led <= sign_r && nz_r;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display: vector table plus handshake corner sequences.
module tb_calc_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  logic        load;
  logic        load_h;
  logic        busy, done, neg_led, err_led;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy_h, done_h, neg_h, err_h;
  logic [6:0]  h0_h, h1_h, h2_h, h3_h;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000;
  localparam logic [6:0] LE = 7'b0000110, LR = 7'b0101111;

  always #5 clk = ~clk;

  calc_result_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .result(result), .load(load),
    .busy(busy), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .neg_led(neg_led), .err_led(err_led)
  );

  calc_result_display #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .result(result), .load(load_h),
    .busy(busy_h), .done(done_h),
    .hex0(h0_h), .hex1(h1_h), .hex2(h2_h), .hex3(h3_h),
    .neg_led(neg_h), .err_led(err_h)
  );

  typedef struct {
    logic [31:0] val;
    logic [6:0]  h3, h2, h1, h0;
    logic        neg, err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] disp(input logic [6:0] a3, a2, a1, a0, input logic n, e);
    return {2'b00, a3, a2, a1, a0, n, e};
  endfunction

  // Load v at edge k and observe 20 edges, counting busy samples and done pulses.
  task automatic convert(input logic [31:0] v, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    result = v;
    load   = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  endtask

  initial begin
    int bc, dc;

    vecs[0] = '{32'd9801,       D9, D8, D0, D1, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFD6,  B,  B,  D4, D2, 1'b1, 1'b0};
    vecs[2] = '{32'd0,          B,  B,  B,  D0, 1'b0, 1'b0};
    vecs[3] = '{32'd10000,      LE, LR, LR, B,  1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000,  LE, LR, LR, B,  1'b0, 1'b1};
    vecs[5] = '{32'd9999,       D9, D9, D9, D9, 1'b0, 1'b0};
    vecs[6] = '{-32'sd9999,     D9, D9, D9, D9, 1'b1, 1'b0};
    vecs[7] = '{-32'sd10000,    LE, LR, LR, B,  1'b0, 1'b1};
    vecs[8] = '{32'd1000,       D1, D0, D0, D0, 1'b0, 1'b0};
    vecs[9] = '{32'd55,         B,  B,  D5, D5, 1'b0, 1'b0};

    rst = 1'b1; load = 1'b0; load_h = 1'b0; result = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_disp", disp(hex3, hex2, hex1, hex0, neg_led, err_led), disp(B, B, B, B, 1'b0, 1'b0));
    check("reset_ctrl", {busy, done}, 2'b00);
    check("reset_disp_hi", {h3_h, h2_h, h1_h, h0_h}, {4{7'b0000000}});

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].val, bc, dc);
      check($sformatf("vec%0d_disp", i), disp(hex3, hex2, hex1, hex0, neg_led, err_led),
            disp(vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0, vecs[i].neg, vecs[i].err));
      check($sformatf("vec%0d_busy_cycles", i), bc, 15);
      check($sformatf("vec%0d_done_pulses", i), dc, 1);
    end

    // Loads at k+5 (CONV) and k+15 (LATCH) must be ignored
    begin
      int dcount;
      dcount = 0;
      @(negedge clk); result = 32'd123; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      for (int e = 1; e <= 20; e++) begin
        @(negedge clk);
        load   = (e == 5) || (e == 15);
        result = load ? 32'd7 : 32'd123;
        @(posedge clk);
        #1 load = 1'b0;
        if (done) dcount++;
        if (e == 14) check("ign_busy_k14", busy, 1'b1);
        if (e == 15) check("ign_busy_k15", busy, 1'b0);
        if (e == 16) check("ign_busy_k16", busy, 1'b0);
      end
      check("ign_done_pulses", dcount, 1);
      check("ign_disp", disp(hex3, hex2, hex1, hex0, neg_led, err_led), disp(B, D1, D2, D3, 1'b0, 1'b0));
    end

    // Reset in the middle of a conversion discards it
    convert(32'd55, bc, dc);
    check("pre_rst_disp", disp(hex3, hex2, hex1, hex0, neg_led, err_led), disp(B, B, D5, D5, 1'b0, 1'b0));
    begin
      int dcount;
      dcount = 0;
      @(negedge clk); result = 32'd99; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("midrst_disp", disp(hex3, hex2, hex1, hex0, neg_led, err_led), disp(B, B, B, B, 1'b0, 1'b0));
      check("midrst_ctrl", {busy, done}, 2'b00);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done || busy) dcount++;
      end
      check("midrst_quiet", dcount, 0);
    end
    convert(32'd99, bc, dc);
    check("post_rst_disp", disp(hex3, hex2, hex1, hex0, neg_led, err_led), disp(B, B, D9, D9, 1'b0, 1'b0));
    check("post_rst_done", dc, 1);

    // rst and load together: reset wins
    @(negedge clk); rst = 1'b1; load = 1'b1; result = 32'd5;
    @(posedge clk); #1 rst = 1'b0; load = 1'b0;
    check("rst_load_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rst_load_busy2", busy, 1'b0);

    // Active-high segment polarity
    @(negedge clk); result = 32'd8; load_h = 1'b1;
    @(posedge clk); #1 load_h = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("hi_disp", {h3_h, h2_h, h1_h, h0_h}, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111});
    check("hi_leds", {neg_h, err_h, busy_h}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_result_display.md
# calc_result_display

Output-side counterpart of the keypad operand reader: takes the calculator's signed 32-bit result and drives four seven-segment digits plus a sign LED. Binary-to-BCD conversion is sequential (shift-add-3, one bit per clock) behind a load/busy/done handshake. The previous result stays on the display until the new one is complete, then all digits change together.

## Interface
- SEG_ACTIVE_LOW, default 1: 1 drives segment codes as listed here; 0 drives their bitwise inverse.
- clk  in  1  system clock; all registers on posedge.
- rst  in  1  synchronous reset, active-high.
- result  in  32  signed two's-complement value to display.
- load  in  1  one-cycle strobe; accepted only in IDLE.
- busy  out  1  high while a conversion is in progress (state != IDLE).
- done  out  1  one-cycle pulse when the outputs update.
- hex0..hex3  out  7 each  segment codes, bit order {g,f,e,d,c,b,a}; hex0 is the ones digit.
- neg_led  out  1  lit for a negative displayed value.
- err_led  out  1  lit when |result| > 9999.

## Operation
- FSM states and transitions:
  - IDLE: on load, go to CONV.
  - CONV: runs 14 iterations, then goes to LATCH.
  - LATCH: goes to IDLE.
- Load capture at edge k (IDLE with load=1):
  - sign = result[31].
  - mag = |result|.
  - ovf = (mag > 9999) or (result == 32'h8000_0000).
  - Shift register = {16'b0 BCD, mag[13:0]}; iteration counter cnt = 0.
- CONV iteration: each of the four BCD nibbles that is ≥5 gets +3, then the combined {bcd, bin} register shifts left by 1; cnt increments. After 14 iterations go to LATCH.
- LATCH registers all outputs:
  - If ovf: hex3="E" (0000110), hex2="r" (0101111), hex1="r", hex0=blank (1111111), err_led=1, neg_led=0.
  - Else: digits are encoded; leading zeros above the most significant nonzero digit are blanked; value 0 shows "0" on hex0 only. neg_led = sign and mag≠0. err_led=0.
- Digit codes:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - blank = 1111111
- load while busy (CONV or LATCH) is ignored, not queued; the captured value is unaffected.

## Timing
- Load sampled at edge k; CONV occupies edges k+1..k+14; LATCH updates hex*/neg_led/err_led and sets done at edge k+15; done clears at edge k+16.
- busy is high from after edge k until after edge k+15 (15 cycles). The next load can be accepted at edge k+16 at the earliest.
- Throughput: one result per 16 cycles.
- Outputs are held constant between LATCH updates. There are no intermediate digit values.
- Reset state, any cycle including mid-conversion: IDLE, cnt=0, all hex* = blank, neg_led=0, err_led=0, done=0, busy=0. A conversion in flight is discarded.
- rst and load in the same cycle: reset wins; load is lost.

## Structure
- Shared package calc_pkg holds:
  - state enum {IDLE, CONV, LATCH}
  - MAX_MAG = 9999
  - BCD_ITER = 14
  - SEG_BLANK, SEG_E, SEG_R, and the digit code constants
- Sub-module seg7_encode: combinational; inputs 4-bit digit and blank; output 7-bit active-low code. Instantiate it four times. The SEG_ACTIVE_LOW inversion is applied at the top level.

## Test plan
- Reset, then load 9801 → after 16 cycles hex3..0 = 9,8,0,1 codes; neg_led=0; err_led=0; done pulses exactly once; busy high for 15 cycles.
- Load −42 (32'hFFFF_FFD6) → hex3/hex2 blank, hex1="4", hex0="2", neg_led=1.
- Load 0, then load 10000 → first result shows blank, blank, blank, "0". Second result shows "E","r","r",blank with err_led=1. Repeat the overflow case with 32'h8000_0000 → same Err display.
- Load 123, then pulse load with 7 at cycles k+5 and k+15 → display shows 123. Neither extra load starts a conversion, and busy falls after edge k+15.
- Display 55, load 99, assert rst at k+7 → all outputs blank, done never pulses, busy=0. A subsequent load of 99 displays "99" correctly.
- With SEG_ACTIVE_LOW=0, load 8 → hex0 = 1111111 and hex1..hex3 = 0000000.
